// File: rtl/pwm_fade_sequencer.sv
// APB master that programs one apb_pwm and ramps its trigger register up and down.
// Define PWM_SEQ_TIMEOUT_EN to abandon transfers whose pready never arrives.
module pwm_fade_sequencer #(
    parameter int INTERVAL_W     = 24,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [31:0]           cfg_reload,
    input  logic [31:0]           cfg_trig_min,
    input  logic [31:0]           cfg_trig_max,
    input  logic [31:0]           cfg_step,
    input  logic [INTERVAL_W-1:0] cfg_interval,
    input  logic [15:0]           cfg_prescaler,
    input  logic                  cfg_active,
    output logic                  busy,
    output logic                  ramp_dir,
    output logic [31:0]           cur_trigger,
    output logic                  err,
    output logic [7:0]            paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [31:0]           pwdata,
    output logic [3:0]            pstrb,
    output logic [2:0]            pprot,
    input  logic                  pready
);
    localparam logic [7:0] ADDR_CFG    = 8'h00;
    localparam logic [7:0] ADDR_RELOAD = 8'h08;
    localparam logic [7:0] ADDR_TRIG   = 8'h0C;

    typedef enum logic [2:0] {
        IDLE, INIT_RELOAD, INIT_TRIG, INIT_CFG, RUN_WAIT, STEP_WR, STOP_CFG
    } state_e;
    typedef enum logic [1:0] {W_IDLE, W_SETUP, W_ACCESS} wr_state_e;

    state_e                state_q, state_d;
    wr_state_e             wr_q, wr_d;
    logic [31:0]           reload_q, reload_d, trig_min_q, trig_min_d;
    logic [31:0]           trig_max_q, trig_max_d, step_q, step_d;
    logic [INTERVAL_W-1:0] interval_q, interval_d, cnt_q, cnt_d, interval_load;
    logic [15:0]           prescaler_q, prescaler_d;
    logic                  active_q, active_d;
    logic [7:0]            addr_q, addr_d, req_addr;
    logic [31:0]           wdata_q, wdata_d, req_data, cur_q, cur_d, next_trig;
    logic                  dir_pend_q, dir_pend_d, ramp_dir_q, ramp_dir_d;
    logic                  stop_pend_q, stop_pend_d, stop_seen;
    logic                  wr_req, wr_done, wr_abort, req_dir, next_dir, start_accept;
    logic [32:0]           sum33, floor33;

    assign start_accept  = (state_q == IDLE) && start && !stop;
    assign stop_seen     = stop_pend_q || stop;
    assign interval_load = (interval_q == '0) ? INTERVAL_W'(1) : interval_q;

    // 33-bit sums keep min + step and cur + step from wrapping near 2^32.
    always_comb begin
        sum33    = {1'b0, cur_q} + {1'b0, step_q};
        floor33  = {1'b0, trig_min_q} + {1'b0, step_q};
        next_trig = cur_q - step_q;
        next_dir  = 1'b1;
        if (!ramp_dir_q) begin
            next_trig = sum33[31:0];
            next_dir  = 1'b0;
            if (sum33 >= {1'b0, trig_max_q}) begin
                next_trig = trig_max_q;
                next_dir  = 1'b1;
            end
        end else if ({1'b0, cur_q} <= floor33) begin
            // Inclusive like the rising clamp: landing exactly on min turns the ramp.
            next_trig = trig_min_q;
            next_dir  = 1'b0;
        end
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path infers a latch.
        state_d     = state_q;
        wr_d        = wr_q;
        reload_d    = reload_q;
        trig_min_d  = trig_min_q;
        trig_max_d  = trig_max_q;
        step_d      = step_q;
        interval_d  = interval_q;
        prescaler_d = prescaler_q;
        active_d    = active_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        dir_pend_d  = dir_pend_q;
        cur_d       = cur_q;
        ramp_dir_d  = ramp_dir_q;
        stop_pend_d = stop_pend_q || ((state_q != IDLE) && stop);
        wr_req      = 1'b0;
        wr_done     = 1'b0;
        req_addr    = ADDR_CFG;
        req_data    = '0;
        req_dir     = ramp_dir_q;

        unique case (state_q)
            INIT_RELOAD: begin wr_req = 1'b1; req_addr = ADDR_RELOAD; req_data = reload_q; end
            INIT_TRIG: begin
                wr_req = 1'b1; req_addr = ADDR_TRIG; req_data = trig_min_q; req_dir = 1'b0;
            end
            INIT_CFG:  begin wr_req = 1'b1; req_data = {prescaler_q, 12'h000, active_q, 3'b010}; end
            STEP_WR: begin
                wr_req = 1'b1; req_addr = ADDR_TRIG; req_data = next_trig; req_dir = next_dir;
            end
            STOP_CFG:  begin wr_req = 1'b1; req_data = {prescaler_q, 12'h000, active_q, 3'b000}; end
            default: ;
        endcase

        // The issuing cycle is itself idle on the bus, giving the mandatory gap between transfers.
        unique case (wr_q)
            W_IDLE: if (wr_req) begin
                wr_d       = W_SETUP;
                addr_d     = req_addr;
                wdata_d    = req_data;
                dir_pend_d = req_dir;
            end
            W_SETUP:  wr_d = W_ACCESS;
            W_ACCESS: if (pready) begin
                wr_d    = W_IDLE;
                wr_done = 1'b1;
            end
            default:  wr_d = W_IDLE;
        endcase

        if (wr_done && (addr_q == ADDR_TRIG)) begin
            cur_d      = wdata_q;
            ramp_dir_d = dir_pend_q;
        end

        unique case (state_q)
            IDLE: if (start_accept) begin
                reload_d    = cfg_reload;
                trig_min_d  = cfg_trig_min;
                trig_max_d  = cfg_trig_max;
                step_d      = cfg_step;
                interval_d  = cfg_interval;
                prescaler_d = cfg_prescaler;
                active_d    = cfg_active;
                state_d     = INIT_RELOAD;
            end
            INIT_RELOAD: if (wr_done) state_d = stop_seen ? STOP_CFG : INIT_TRIG;
            INIT_TRIG:   if (wr_done) state_d = stop_seen ? STOP_CFG : INIT_CFG;
            INIT_CFG, STEP_WR: if (wr_done) begin
                state_d = stop_seen ? STOP_CFG : RUN_WAIT;
                cnt_d   = interval_load;
            end
            RUN_WAIT: begin
                if (stop_seen)                  state_d = STOP_CFG;
                else if (cnt_q > INTERVAL_W'(1)) cnt_d   = cnt_q - INTERVAL_W'(1);
                else if (trig_min_q < trig_max_q) state_d = STEP_WR;
                else                            cnt_d   = interval_load;
            end
            STOP_CFG: if (wr_done) begin
                state_d     = IDLE;
                stop_pend_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (wr_abort) begin
            wr_d        = W_IDLE;
            state_d     = IDLE;
            stop_pend_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; next values come from always_comb.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q     <= IDLE;
            wr_q        <= W_IDLE;
            reload_q    <= '0;
            trig_min_q  <= '0;
            trig_max_q  <= '0;
            step_q      <= '0;
            interval_q  <= '0;
            prescaler_q <= '0;
            active_q    <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            dir_pend_q  <= 1'b0;
            cur_q       <= '0;
            ramp_dir_q  <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            reload_q    <= reload_d;
            trig_min_q  <= trig_min_d;
            trig_max_q  <= trig_max_d;
            step_q      <= step_d;
            interval_q  <= interval_d;
            prescaler_q <= prescaler_d;
            active_q    <= active_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            dir_pend_q  <= dir_pend_d;
            cur_q       <= cur_d;
            ramp_dir_q  <= ramp_dir_d;
            stop_pend_q <= stop_pend_d;
        end
    end

`ifdef PWM_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;

    assign wr_abort = (wr_q == W_ACCESS) && !pready && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        to_cnt_d = (wr_q == W_ACCESS) ? to_cnt_q + TO_W'(1) : '0;
        err_d    = err_q;
        if (start_accept)  err_d = 1'b0;
        else if (wr_abort) err_d = 1'b1;
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;
`else
    // Transfers wait for pready forever; the comparison is constant false.
    assign wr_abort = (TIMEOUT_CYCLES < 0);
    assign err      = 1'b0;
`endif

    assign busy        = (state_q != IDLE);
    assign ramp_dir    = ramp_dir_q;
    assign cur_trigger = cur_q;
    assign paddr       = addr_q;
    assign pwdata      = wdata_q;
    assign psel        = (wr_q != W_IDLE);
    assign penable     = (wr_q == W_ACCESS);
    assign pwrite      = 1'b1;
    assign pstrb       = 4'hF;
    assign pprot       = 3'b000;
endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Scoreboard bench for pwm_fade_sequencer: expected APB writes are queued by the stimulus,
// a negedge monitor compares each completed transfer (address, data, length, spacing).
module tb_pwm_fade_sequencer;
    localparam int IW = 24;

    logic          pclk = 1'b0;
    logic          preset_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [31:0]   cfg_reload = '0, cfg_trig_min = '0, cfg_trig_max = '0, cfg_step = '0;
    logic [IW-1:0] cfg_interval = '0;
    logic [15:0]   cfg_prescaler = '0;
    logic          cfg_active = 1'b0;
    logic          busy, ramp_dir, err, psel, penable, pwrite;
    logic [31:0]   cur_trigger, pwdata;
    logic [7:0]    paddr;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic          pready = 1'b1;

    pwm_fade_sequencer #(.INTERVAL_W(IW), .TIMEOUT_CYCLES(16)) dut (
        .pclk(pclk), .preset_n(preset_n), .start(start), .stop(stop),
        .cfg_reload(cfg_reload), .cfg_trig_min(cfg_trig_min), .cfg_trig_max(cfg_trig_max),
        .cfg_step(cfg_step), .cfg_interval(cfg_interval), .cfg_prescaler(cfg_prescaler),
        .cfg_active(cfg_active), .busy(busy), .ramp_dir(ramp_dir), .cur_trigger(cur_trigger),
        .err(err), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .pready(pready)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          len;
        int          gap;
        bit          chk_cur;
        logic        dir;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   stall_req = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [31:0] d, input int len,
                             input int gap, input bit chk, input logic dir);
        exp_t e;
        e.addr = a; e.data = d; e.len = len; e.gap = gap; e.chk_cur = chk; e.dir = dir;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] cfg_word(input logic [15:0] presc, input logic act,
                                             input logic en);
        return {presc, 12'h000, act, 1'b0, en, 1'b0};
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_cfg(input logic [31:0] rl, input logic [31:0] mn, input logic [31:0] mx,
                           input logic [31:0] st, input logic [IW-1:0] iv,
                           input logic [15:0] ps, input logic ac);
        cfg_reload = rl; cfg_trig_min = mn; cfg_trig_max = mx; cfg_step = st;
        cfg_interval = iv; cfg_prescaler = ps; cfg_active = ac;
    endtask

    task automatic pulse_start(input string name);
        start = 1'b1;
        tick();
        start = 1'b0;
        check(name, 32'(busy), 32'd1);
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_trig_setup(input string name, input int max_cycles);
        int n = 0;
        while (!(psel && !penable && paddr == 8'h0C) && n < max_cycles) begin
            tick();
            n++;
        end
        check(name, 32'(n < max_cycles), 32'd1);
    endtask

    // APB slave: pready low for stall_req access cycles, otherwise ready at once.
    always @(negedge pclk) begin
        if (psel && penable && stall_req > 0) begin
            pready = 1'b0;
            stall_req--;
        end else begin
            pready = 1'b1;
        end
    end

    int          cyc = 0, last_end = 0, setup_cyc = 0, xlen = 0;
    bit          in_xfer = 1'b0;
    logic [7:0]  a0;
    logic [31:0] d0;

    always @(negedge pclk) begin
        exp_t e;
        cyc++;
        if (!preset_n) begin
            in_xfer = 1'b0;
        end else if (psel) begin
            if (!in_xfer) begin
                in_xfer = 1'b1; xlen = 1; a0 = paddr; d0 = pwdata; setup_cyc = cyc;
                check("setup_penable", 32'(penable), 32'd0);
                check("pwrite", 32'(pwrite), 32'd1);
                check("pstrb", 32'(pstrb), 32'hF);
                check("pprot", 32'(pprot), 32'd0);
            end else begin
                xlen++;
                check("access_penable", 32'(penable), 32'd1);
                check("paddr_stable", 32'(paddr), 32'(a0));
                check("pwdata_stable", pwdata, d0);
            end
        end else if (in_xfer) begin
            in_xfer = 1'b0;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%02h data 0x%08h while none expected",
                         a0, d0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(a0), 32'(e.addr));
                check("wr_data", d0, e.data);
                check("wr_len", 32'(xlen), 32'(e.len));
                if (e.gap != 0) check("wr_gap", 32'(setup_cyc - last_end), 32'(e.gap));
                if (e.chk_cur) begin
                    check("cur_trigger", cur_trigger, e.data);
                    check("ramp_dir", 32'(ramp_dir), 32'(e.dir));
                end
            end
            last_end = cyc;
        end
    end

    initial begin
        // Reset values.
        #2;
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cur", cur_trigger, 32'd0);
        check("rst_dir", 32'(ramp_dir), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_paddr", 32'(paddr), 32'd0);
        check("rst_pwdata", pwdata, 32'd0);
        repeat (2) @(posedge pclk);
        #1 preset_n = 1'b1;
        tick();

        // start and stop together from IDLE: stop wins.
        set_cfg(999, 100, 900, 200, 10, 3, 1'b1);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("start_stop_busy", 32'(busy), 32'd0);
        repeat (5) tick();
        check("start_stop_idle", 32'(busy), 32'd0);

        // Init sequence and full triangle ramp; cfg inputs scrambled after start.
        expect_wr(8'h08, 32'd999, 2, 0, 1'b0, 1'b0);
        expect_wr(8'h0C, 32'd100, 2, 1, 1'b1, 1'b0);
        expect_wr(8'h00, 32'h0003_000A, 2, 1, 1'b0, 1'b0);
        expect_wr(8'h0C, 32'd300, 2, 11, 1'b1, 1'b0);
        expect_wr(8'h0C, 32'd500, 2, 11, 1'b1, 1'b0);
        expect_wr(8'h0C, 32'd700, 2, 11, 1'b1, 1'b0);
        expect_wr(8'h0C, 32'd900, 2, 11, 1'b1, 1'b1);
        expect_wr(8'h0C, 32'd700, 2, 11, 1'b1, 1'b1);
        expect_wr(8'h0C, 32'd500, 2, 11, 1'b1, 1'b1);
        expect_wr(8'h0C, 32'd300, 2, 11, 1'b1, 1'b1);
        expect_wr(8'h0C, 32'd100, 2, 11, 1'b1, 1'b0);
        expect_wr(8'h0C, 32'd300, 2, 11, 1'b1, 1'b0);
        pulse_start("ramp_busy");
        set_cfg(32'h1234, 7, 8, 1, 2, 16'h00FF, 1'b0);
        repeat (30) tick();
        pulse_start("start_while_busy");
        wait_drain("ramp_drain", 400);

        // Stop during SETUP of the next trigger write.
        wait_trig_setup("stop_setup_seen", 40);
        expect_wr(8'h0C, 32'd500, 2, 11, 1'b1, 1'b0);
        expect_wr(8'h00, 32'h0003_0008, 2, 1, 1'b0, 1'b0);
        pulse_stop();
        wait_drain("stop_drain", 20);
        check("stop_busy", 32'(busy), 32'd0);
        repeat (30) tick();
        check("stop_quiet_busy", 32'(busy), 32'd0);

        // min == max: init writes only, then an explicit stop.
        set_cfg(10, 50, 50, 5, 3, 16'h0012, 1'b0);
        expect_wr(8'h08, 32'd10, 2, 0, 1'b0, 1'b0);
        expect_wr(8'h0C, 32'd50, 2, 1, 1'b1, 1'b0);
        expect_wr(8'h00, cfg_word(16'h0012, 1'b0, 1'b1), 2, 1, 1'b0, 1'b0);
        pulse_start("flat_busy");
        wait_drain("flat_drain", 40);
        repeat (40) tick();
        check("flat_still_busy", 32'(busy), 32'd1);
        expect_wr(8'h00, cfg_word(16'h0012, 1'b0, 1'b0), 2, 0, 1'b0, 1'b0);
        pulse_stop();
        wait_drain("flat_stop_drain", 20);
        check("flat_stop_busy", 32'(busy), 32'd0);

        // Near-32-bit bounds: no wrap on the rising sum; interval 0 acts as 1.
        set_cfg(32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 32'hC000_0000, 0, 16'h0001, 1'b1);
        expect_wr(8'h08, 32'hFFFF_FFFF, 2, 0, 1'b0, 1'b0);
        expect_wr(8'h0C, 32'h0000_0000, 2, 1, 1'b1, 1'b0);
        expect_wr(8'h00, 32'h0001_000A, 2, 1, 1'b0, 1'b0);
        expect_wr(8'h0C, 32'hC000_0000, 2, 2, 1'b1, 1'b0);
        expect_wr(8'h0C, 32'hFFFF_FFFF, 2, 2, 1'b1, 1'b1);
        pulse_start("wrap_busy");
        wait_drain("wrap_drain", 60);
        wait_trig_setup("wrap_setup_seen", 10);
        expect_wr(8'h0C, 32'h3FFF_FFFF, 2, 2, 1'b1, 1'b1);
        expect_wr(8'h00, 32'h0001_0008, 2, 1, 1'b0, 1'b0);
        pulse_stop();
        wait_drain("wrap_stop_drain", 20);
        check("wrap_stop_busy", 32'(busy), 32'd0);

        // Five-cycle stall on the reload write, then reset during the trigger write's access.
        set_cfg(999, 100, 900, 200, 10, 3, 1'b1);
        stall_req = 5;
        expect_wr(8'h08, 32'd999, 7, 0, 1'b0, 1'b0);
        pulse_start("stall_busy");
        begin
            int n = 0;
            while (!(psel && penable && paddr == 8'h0C) && n < 40) begin
                tick();
                n++;
            end
            check("reset_access_seen", 32'(n < 40), 32'd1);
        end
        check("stall_popped", 32'(exp_q.size()), 32'd0);
        preset_n = 1'b0;
        #1;
        check("arst_psel", 32'(psel), 32'd0);
        check("arst_penable", 32'(penable), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_paddr", 32'(paddr), 32'd0);
        check("arst_pwdata", pwdata, 32'd0);
        check("arst_cur", cur_trigger, 32'd0);
        @(negedge pclk);
        @(posedge pclk);
        #3 preset_n = 1'b1;
        repeat (20) tick();
        check("arst_idle_busy", 32'(busy), 32'd0);

`ifdef PWM_SEQ_TIMEOUT_EN
        // pready never comes: abandoned after 16 access cycles, err sticky until next start.
        stall_req = 1000;
        expect_wr(8'h08, 32'd999, 17, 0, 1'b0, 1'b0);
        pulse_start("to_busy");
        begin
            int n = 0;
            while (busy && n < 60) begin
                tick();
                n++;
            end
            check("to_busy_fell", 32'(busy), 32'd0);
        end
        stall_req = 0;
        tick();
        check("to_err_set", 32'(err), 32'd1);
        check("to_drain", 32'(exp_q.size()), 32'd0);
        expect_wr(8'h08, 32'd999, 2, 0, 1'b0, 1'b0);
        expect_wr(8'h0C, 32'd100, 2, 1, 1'b1, 1'b0);
        expect_wr(8'h00, 32'h0003_000A, 2, 1, 1'b0, 1'b0);
        pulse_start("to_restart_busy");
        check("to_err_cleared", 32'(err), 32'd0);
        wait_drain("to_init_drain", 40);
        expect_wr(8'h00, 32'h0003_0008, 2, 0, 1'b0, 1'b0);
        pulse_stop();
        wait_drain("to_stop_drain", 20);
`else
        check("err_tied_low", 32'(err), 32'd0);
`endif

        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
